// File: rtl/branch_unit_if.sv
// Fetch-side bus of branch_unit: instruction/operands in, PC redirect controls and flags out.
// Optional counters exist only when BRANCH_UNIT_STATS_EN is defined.
interface branch_unit_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  flags_in;
  logic        flags_wr;
  logic        rt_zero;
  logic [63:0] reg_target;
  logic [63:0] pc_plus_four;
  logic        BrTaken;
  logic        UncondBr;
  logic [18:0] CondAddr19;
  logic [25:0] BrAddr26;
  logic        pc_rd;
  logic [63:0] pc_ext;
  logic        link_wr;
  logic [63:0] link_data;
  logic        flush;
  logic [3:0]  flags_q;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] br_count;
  logic [31:0] br_taken_count;
`endif

  modport master (
    output instr, instr_valid, flags_in, flags_wr, rt_zero, reg_target, pc_plus_four,
    input  BrTaken, UncondBr, CondAddr19, BrAddr26, pc_rd, pc_ext, link_wr, link_data,
           flush, flags_q
`ifdef BRANCH_UNIT_STATS_EN
    , input br_count, br_taken_count
`endif
  );

  modport slave (
    input  instr, instr_valid, flags_in, flags_wr, rt_zero, reg_target, pc_plus_four,
    output BrTaken, UncondBr, CondAddr19, BrAddr26, pc_rd, pc_ext, link_wr, link_data,
           flush, flags_q
`ifdef BRANCH_UNIT_STATS_EN
    , output br_count, br_taken_count
`endif
  );
endinterface

// File: rtl/branch_unit.sv
// LEGv8 branch decode, NZCV flags register and post-redirect squash FSM; redirect outputs are
// combinational from instr, squash lasts FLUSH_CYCLES (0..7). Counters under BRANCH_UNIT_STATS_EN.
module branch_unit #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  branch_unit_if.slave  bu
);
  typedef enum logic {RUN, FLUSH} state_t;

  localparam int unsigned FC_M1    = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam logic [2:0]  CNT_INIT = FC_M1[2:0];

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [3:0]  nzcv_q, nzcv_d;
  logic        is_b, is_bl, is_cbz, is_cbnz, is_bcond, is_br;
  logic        active, base_true, cond_true, taken, redirect;
  logic        n, z, c, v;

  assign {n, z, c, v} = nzcv_q;

  always_comb begin
    is_b     = (bu.instr[31:26] == 6'b000101);
    is_bl    = (bu.instr[31:26] == 6'b100101);
    is_cbz   = (bu.instr[31:24] == 8'b10110100);
    is_cbnz  = (bu.instr[31:24] == 8'b10110101);
    is_bcond = (bu.instr[31:24] == 8'b01010100);
    is_br    = (bu.instr[31:10] == 22'b1101011000011111000000);
  end

  // Odd condition codes are the negation of the even one below them, except NV (always true).
  always_comb begin
    base_true = 1'b1;
    case (bu.instr[3:1])
      3'b000:  base_true = z;
      3'b001:  base_true = c;
      3'b010:  base_true = n;
      3'b011:  base_true = v;
      3'b100:  base_true = c & ~z;
      3'b101:  base_true = (n == v);
      3'b110:  base_true = ~z & (n == v);
      default: base_true = 1'b1;
    endcase
    cond_true = (bu.instr[0] && (bu.instr[3:1] != 3'b111)) ? ~base_true : base_true;
  end

  assign active   = bu.instr_valid && !reset && (state_q == RUN);
  assign taken    = active && (is_b || is_bl || (is_cbz && bu.rt_zero) ||
                               (is_cbnz && !bu.rt_zero) || (is_bcond && cond_true));
  assign redirect = taken || (active && is_br);
  assign nzcv_d   = (active && bu.flags_wr) ? bu.flags_in : nzcv_q;

  assign bu.BrTaken    = taken;
  assign bu.UncondBr   = active && (is_b || is_bl);
  assign bu.pc_rd      = active && is_br;
  assign bu.link_wr    = active && is_bl;
  assign bu.CondAddr19 = bu.instr[23:5];
  assign bu.BrAddr26   = bu.instr[25:0];
  assign bu.pc_ext     = bu.reg_target;
  assign bu.link_data  = bu.pc_plus_four;
  assign bu.flush      = (state_q == FLUSH) && !reset;
  assign bu.flags_q    = reset ? 4'd0 : nzcv_q;

  always_ff @(posedge clk) begin
    if (reset) nzcv_q <= 4'd0;
    else       nzcv_q <= nzcv_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect && (FLUSH_CYCLES > 0)) begin
            state_q <= FLUSH;
            cnt_q   <= CNT_INIT;
          end
        end
        FLUSH: begin
          if (cnt_q == 3'd0) state_q <= RUN;
          else               cnt_q   <= cnt_q - 3'd1;
        end
      endcase
    end
  end

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] br_cnt_q, tk_cnt_q;
  logic        is_branch;

  assign is_branch = is_b || is_bl || is_cbz || is_cbnz || is_bcond || is_br;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q <= 32'd0;
      tk_cnt_q <= 32'd0;
    end else begin
      if (active && is_branch && (br_cnt_q != 32'hFFFF_FFFF)) br_cnt_q <= br_cnt_q + 32'd1;
      if (redirect && (tk_cnt_q != 32'hFFFF_FFFF))            tk_cnt_q <= tk_cnt_q + 32'd1;
    end
  end

  assign bu.br_count       = reset ? 32'd0 : br_cnt_q;
  assign bu.br_taken_count = reset ? 32'd0 : tk_cnt_q;
`endif
endmodule

// File: tb/tb_branch_unit.sv
// Three branch_unit instances (FLUSH_CYCLES 1, 3, 0) share stimulus; expectations from a spec-level model are queued and checked by a monitor.
module tb_branch_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  localparam int FC[3] = '{1, 3, 0};

  typedef struct packed {
    logic        br_taken;
    logic        uncond;
    logic        pc_rd;
    logic        link_wr;
    logic        flush;
    logic [3:0]  flags;
    logic [18:0] ca19;
    logic [25:0] ba26;
    logic [63:0] pc_ext;
    logic [63:0] link_data;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] brc;
    logic [31:0] tkc;
`endif
  } exp_t;

  branch_unit_if if1();
  branch_unit_if if3();
  branch_unit_if if0();

  branch_unit #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bu(if1.slave));
  branch_unit #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bu(if3.slave));
  branch_unit #(.FLUSH_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bu(if0.slave));

  exp_t act[3];
  assign act[0] = {if1.BrTaken, if1.UncondBr, if1.pc_rd, if1.link_wr, if1.flush, if1.flags_q,
                   if1.CondAddr19, if1.BrAddr26, if1.pc_ext, if1.link_data
`ifdef BRANCH_UNIT_STATS_EN
                   , if1.br_count, if1.br_taken_count
`endif
                   };
  assign act[1] = {if3.BrTaken, if3.UncondBr, if3.pc_rd, if3.link_wr, if3.flush, if3.flags_q,
                   if3.CondAddr19, if3.BrAddr26, if3.pc_ext, if3.link_data
`ifdef BRANCH_UNIT_STATS_EN
                   , if3.br_count, if3.br_taken_count
`endif
                   };
  assign act[2] = {if0.BrTaken, if0.UncondBr, if0.pc_rd, if0.link_wr, if0.flush, if0.flags_q,
                   if0.CondAddr19, if0.BrAddr26, if0.pc_ext, if0.link_data
`ifdef BRANCH_UNIT_STATS_EN
                   , if0.br_count, if0.br_taken_count
`endif
                   };

  // Reference model state, one slot per instance
  logic [3:0]  flags_m [3];
  int          left_m  [3];
  logic [31:0] brc_m   [3];
  logic [31:0] tkc_m   [3];
  exp_t        q [3][$];

  int n_chk  = 0;
  int n_fail = 0;

  localparam int C_NONE = 0, C_B = 1, C_BL = 2, C_CBZ = 3, C_CBNZ = 4, C_BCOND = 5, C_BR = 6;

  function automatic int classify(input logic [31:0] ins);
    if (ins[31:26] == 6'b000101) return C_B;
    if (ins[31:26] == 6'b100101) return C_BL;
    if (ins[31:24] == 8'hB4)     return C_CBZ;
    if (ins[31:24] == 8'hB5)     return C_CBNZ;
    if (ins[31:24] == 8'h54)     return C_BCOND;
    if (ins[31:10] == 22'b1101011000011111000000) return C_BR;
    return C_NONE;
  endfunction

  function automatic bit cond_holds(input logic [3:0] f, input logic [3:0] cond);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !(c && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  task automatic model(input int k, input logic rst, input logic [31:0] ins, input logic vld,
                       input logic [3:0] fin, input logic fwr, input logic rz,
                       input logic [63:0] rt, input logic [63:0] p4, output exp_t e);
    bit in_fl, act_now, tk, prd;
    int cls;
    e = '0;
    e.ca19      = ins[23:5];
    e.ba26      = ins[25:0];
    e.pc_ext    = rt;
    e.link_data = p4;
    if (rst) begin
      flags_m[k] = 4'd0; left_m[k] = 0; brc_m[k] = 32'd0; tkc_m[k] = 32'd0;
      return;
    end
    in_fl   = left_m[k] > 0;
    act_now = vld && !in_fl;
    cls     = classify(ins);
    tk      = 1'b0;
    prd     = 1'b0;
    if (act_now) begin
      case (cls)
        C_B, C_BL: begin tk = 1'b1; e.uncond = 1'b1; e.link_wr = (cls == C_BL); end
        C_CBZ:     tk = rz;
        C_CBNZ:    tk = !rz;
        C_BCOND:   tk = cond_holds(flags_m[k], ins[3:0]);
        C_BR:      prd = 1'b1;
        default:   ;
      endcase
    end
    e.br_taken = tk;
    e.pc_rd    = prd;
    e.flush    = in_fl;
    e.flags    = flags_m[k];
`ifdef BRANCH_UNIT_STATS_EN
    e.brc = brc_m[k];
    e.tkc = tkc_m[k];
`endif
    if (in_fl) begin
      left_m[k] = left_m[k] - 1;
    end else if (act_now) begin
      if (fwr) flags_m[k] = fin;
      if (tk || prd) left_m[k] = FC[k];
      if (cls != C_NONE && brc_m[k] != 32'hFFFF_FFFF) brc_m[k] = brc_m[k] + 1;
      if ((tk || prd) && tkc_m[k] != 32'hFFFF_FFFF) tkc_m[k] = tkc_m[k] + 1;
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] ins, input logic vld,
                      input logic [3:0] fin, input logic fwr, input logic rz,
                      input logic [63:0] rt, input logic [63:0] p4);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    if1.instr = ins; if1.instr_valid = vld; if1.flags_in = fin; if1.flags_wr = fwr;
    if1.rt_zero = rz; if1.reg_target = rt; if1.pc_plus_four = p4;
    if3.instr = ins; if3.instr_valid = vld; if3.flags_in = fin; if3.flags_wr = fwr;
    if3.rt_zero = rz; if3.reg_target = rt; if3.pc_plus_four = p4;
    if0.instr = ins; if0.instr_valid = vld; if0.flags_in = fin; if0.flags_wr = fwr;
    if0.rt_zero = rz; if0.reg_target = rt; if0.pc_plus_four = p4;
    for (int k = 0; k < 3; k++) begin
      model(k, rst, ins, vld, fin, fwr, rz, rt, p4, e);
      q[k].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h8B000000, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
  endtask

  task automatic chk(input string nm, input int k, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s dut(FLUSH_CYCLES=%0d) t=%0t: got %0h expected %0h", nm, FC[k], $time, a, e);
    end
  endtask

  // Monitor: each instance presents a response every cycle
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (q[k].size() > 0) begin
        exp_t e, a;
        e = q[k].pop_front();
        a = act[k];
        chk("BrTaken",    k, 64'(a.br_taken),  64'(e.br_taken));
        chk("UncondBr",   k, 64'(a.uncond),    64'(e.uncond));
        chk("pc_rd",      k, 64'(a.pc_rd),     64'(e.pc_rd));
        chk("link_wr",    k, 64'(a.link_wr),   64'(e.link_wr));
        chk("flush",      k, 64'(a.flush),     64'(e.flush));
        chk("flags_q",    k, 64'(a.flags),     64'(e.flags));
        chk("CondAddr19", k, 64'(a.ca19),      64'(e.ca19));
        chk("BrAddr26",   k, 64'(a.ba26),      64'(e.ba26));
        chk("pc_ext",     k, a.pc_ext,         e.pc_ext);
        chk("link_data",  k, a.link_data,      e.link_data);
`ifdef BRANCH_UNIT_STATS_EN
        chk("br_count",       k, 64'(a.brc), 64'(e.brc));
        chk("br_taken_count", k, 64'(a.tkc), 64'(e.tkc));
`endif
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {6'b000101, r[25:0]};
      1: return {6'b100101, r[25:0]};
      2: return {8'hB4, r[23:0]};
      3: return {8'hB5, r[23:0]};
      4, 5: return {8'h54, r[23:0]};
      6: return {22'b1101011000011111000000, r[9:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < 3; k++) begin
      flags_m[k] = 4'd0; left_m[k] = 0; brc_m[k] = 32'd0; tkc_m[k] = 32'd0;
    end
    reset = 1'b1;
    step(1'b1, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b1, 32'h14000148, 1'b1, 4'hF, 1'b1, 1'b1, 64'd7, 64'd9);
    // B imm26=328, then squash window
    step(1'b0, 32'h14000148, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'h100);
    idle(4);
    // BL with link
    step(1'b0, 32'h94000004, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'h104);
    idle(4);
    // SUBS sets Z, then B.EQ taken
    step(1'b0, 32'hEB010000, 1'b1, 4'b0100, 1'b1, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h54001480, 1'b1, 4'b0000, 1'b0, 1'b0, 64'd0, 64'd0);
    idle(4);
    // flags cleared: B.EQ not taken, no squash
    step(1'b1, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h54001480, 1'b1, 4'b0100, 1'b1, 1'b0, 64'd0, 64'd0);
    idle(1);
    // CBZ taken, CBNZ not taken
    step(1'b0, 32'hB4000123, 1'b1, 4'd0, 1'b0, 1'b1, 64'd0, 64'd0);
    idle(4);
    step(1'b0, 32'hB5000123, 1'b1, 4'd0, 1'b0, 1'b1, 64'd0, 64'd0);
    idle(1);
    // B.GT with N=V=1, Z=0 then N=1, V=0
    step(1'b0, 32'hEB010000, 1'b1, 4'b1001, 1'b1, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h5400002C, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    idle(4);
    step(1'b0, 32'hEB010000, 1'b1, 4'b1000, 1'b1, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h5400002C, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    idle(1);
    // BR X5, then taken B offered during squash; one bubble with instr_valid=0
    step(1'b0, 32'hD61F00A0, 1'b1, 4'd0, 1'b0, 1'b0, 64'd45826, 64'd0);
    step(1'b0, 32'h14000010, 1'b1, 4'hF, 1'b1, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h14000010, 1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h14000010, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    idle(4);
    // reset mid-squash
    step(1'b0, 32'h14000001, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b1, 32'h14000001, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h14000002, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    idle(4);
    // back-to-back taken branches
    for (int i = 0; i < 4; i++) step(1'b0, 32'h14000020 + 32'(i), 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    idle(4);
    // five branches, three taken
    step(1'b1, 32'd0, 1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'h14000008, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    idle(4);
    step(1'b0, 32'hB5000000, 1'b1, 4'd0, 1'b0, 1'b1, 64'd0, 64'd0);
    step(1'b0, 32'hB4000000, 1'b1, 4'd0, 1'b0, 1'b1, 64'd0, 64'd0);
    idle(4);
    step(1'b0, 32'h54000000, 1'b1, 4'd0, 1'b0, 1'b0, 64'd0, 64'd0);
    step(1'b0, 32'hD61F0000, 1'b1, 4'd0, 1'b0, 1'b0, 64'd5, 64'd0);
    idle(4);
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 39) == 0, rand_instr(), $urandom_range(0, 3) != 0,
           4'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
           {$urandom, $urandom}, {$urandom, $urandom});
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("queue_drain", k, 64'(q[k].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- Decodes the branch class of each fetched 32-bit LEGv8 instruction and drives the redirect inputs of the program counter: BrTaken, UncondBr, CondAddr19, BrAddr26, pc_rd, pc_ext.
- Holds the architectural NZCV flags register, evaluates B.cond and CBZ/CBNZ, and requests the X30 link write for BL.
- After every redirect it squashes younger fetched instructions for a configurable number of cycles.

Parameters:
- FLUSH_CYCLES, 1: cycles squashed after a redirect. 0 means no squash, so the FLUSH state is never entered. Legal range is 0..7.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- instr  input  32  instruction fetched at the current pc_out
- instr_valid  input  1  instr is meaningful this cycle
- flags_in  input  4  {N,Z,C,V} from the ALU for the current instruction
- flags_wr  input  1  current instruction sets flags (ADDS/SUBS)
- rt_zero  input  1  register-file read of Rt equals 0 (CBZ/CBNZ)
- reg_target  input  64  register-file read of Rn (BR)
- pc_plus_four  input  64  PCPlusFour from the program counter
- BrTaken  output  1  take PC-relative branch
- UncondBr  output  1  1 selects BrAddr26, 0 selects CondAddr19
- CondAddr19  output  19  instr[23:5]
- BrAddr26  output  26  instr[25:0]
- pc_rd  output  1  load PC from pc_ext
- pc_ext  output  64  absolute target
- link_wr  output  1  write X30
- link_data  output  64  value for X30
- flush  output  1  current instr is squashed
- flags_q  output  4  registered {N,Z,C,V}

Behaviour:
- Decode (combinational, same cycle as instr; PC updates at the next edge):
  - B: instr[31:26]=000101
  - BL: instr[31:26]=100101
  - CBZ: instr[31:24]=10110100
  - CBNZ: instr[31:24]=10110101
  - B.cond: instr[31:24]=01010100, cond=instr[3:0]
  - BR: instr[31:10]=1101011000011111000000, Rn=instr[9:5]
  - Anything else is non-branch.
- CondAddr19 and BrAddr26 are always the raw instr fields. pc_ext is always reg_target. link_data is always pc_plus_four.
- "Active" means instr_valid=1, reset=0, and state is RUN.
- B and BL: when active, BrTaken=1, UncondBr=1. BL also asserts link_wr=1.
- CBZ/CBNZ: UncondBr=0. BrTaken=rt_zero for CBZ, ~rt_zero for CBNZ.
- B.cond: UncondBr=0, BrTaken=cond_true(flags_q). The condition uses the registered flags only; an ADDS in the same cycle does not affect it.
  - EQ Z; NE ~Z; HS C; LO ~C; MI N; PL ~N; VS V; VC ~V
  - HI C&~Z; LS ~(C&~Z); GE N==V; LT N!=V
  - GT ~Z&(N==V); LE ~(~Z&(N==V)); AL and NV are always true.
- BR: pc_rd=1, BrTaken=0, UncondBr=0.
- When not active, BrTaken, UncondBr, pc_rd and link_wr are all 0.
- Flags register: on a clock edge with reset, flags_q<=0. Otherwise, if active and flags_wr, flags_q<=flags_in. Otherwise it holds.
- FSM, states RUN and FLUSH, with a 3-bit counter cnt:
  - Reset: state=RUN, cnt=0.
  - RUN: if active and (BrTaken or pc_rd) and FLUSH_CYCLES>0, go to FLUSH with cnt<=FLUSH_CYCLES-1.
  - FLUSH: flush=1. All redirect outputs and link_wr are forced to 0, and flags_wr is ignored. If cnt==0 go to RUN, else cnt<=cnt-1.
  - instr_valid=0 during FLUSH still consumes a flush cycle.
- Not-taken conditional branches never enter FLUSH.
- Reset mid-FLUSH returns to RUN immediately. While reset is high, all outputs are 0 except the raw field outputs and pass-through outputs.
- Back-to-back taken branches with FLUSH_CYCLES=0 are each honoured.

Optional Feature:
- Macro BRANCH_UNIT_STATS_EN.
- When defined, adds two outputs, br_count (32 bits) and br_taken_count (32 bits), both reset to 0.
  - br_count increments on every active branch-class instruction, whether taken or not.
  - br_taken_count increments on every active redirect (BrTaken or pc_rd).
  - Both counters saturate at 32'hFFFFFFFF and do not wrap.
- When not defined, these ports and counters do not exist. Behaviour is otherwise identical.

Test Plan:
- Reset and FLUSH_CYCLES=1, instr=B with imm26=328 (0x14000148), instr_valid=1 -> BrTaken=1, UncondBr=1, BrAddr26=328, link_wr=0. Next cycle flush=1, BrTaken=0. The cycle after that, flush=0.
- BL with imm26=4, pc_plus_four=0x104 -> BrTaken=1, UncondBr=1, link_wr=1, link_data=0x104.
- SUBS with flags_wr=1, flags_in=0100, then B.EQ with imm19=164 (0x54001480) -> flags_q=0100, BrTaken=1, UncondBr=0, CondAddr19=164. With flags_q=0000 instead -> BrTaken=0 and no flush.
- CBZ with rt_zero=1 -> BrTaken=1. CBNZ with rt_zero=1 -> BrTaken=0. B.GT with flags_q N=1, V=1, Z=0 -> taken. B.GT with N=1, V=0 -> not taken.
- BR X5 (0xD61F00A0), reg_target=45826 -> pc_rd=1, pc_ext=45826, BrTaken=0. Then FLUSH_CYCLES=3: flush high for exactly 3 cycles, and a taken B presented during those cycles is ignored.
- Assert reset during FLUSH -> next cycle state=RUN, flags_q=0, flush=0. With BRANCH_UNIT_STATS_EN defined: 5 branches of which 3 are taken -> br_count=5, br_taken_count=3.
